// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch: FSM state encoding and default timing constants.
package stopwatch_pkg;

   localparam int unsigned CLK_HZ        = 50_000_000;
   localparam int unsigned TICK_10MS     = 500_000;
   localparam int unsigned DEBOUNCE_20MS = 1_000_000;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUNNING = 2'd1;
   localparam logic [1:0] ST_LAP     = 2'd2;
   localparam logic [1:0] ST_PAUSED  = 2'd3;

   typedef enum logic [1:0] {
      StIdle    = ST_IDLE,
      StRunning = ST_RUNNING,
      StLap     = ST_LAP,
      StPaused  = ST_PAUSED
   } state_e;

   function automatic logic is_running(input state_e s);
      return (s == StRunning) || (s == StLap);
   endfunction

endpackage

// File: rtl/stopwatch_control_if.sv
// Button inputs and control outputs between the board/test harness and stopwatch_control.
interface stopwatch_control_if;

   logic       start_stop_n;
   logic       clear_lap_n;
   logic       tick;
   logic       count_clear;
   logic       freeze;
   logic       running;
   logic [1:0] state;

   modport master (
      output start_stop_n, clear_lap_n,
      input  tick, count_clear, freeze, running, state
   );

   modport slave (
      input  start_stop_n, clear_lap_n,
      output tick, count_clear, freeze, running, state
   );

endinterface

// File: rtl/button_debounce.sv
// Synchronizes and debounces one active-low pushbutton; emits a one-cycle press pulse.
module button_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clock,
   input  logic reset,
   input  logic key_n_i,
   output logic press_o
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            stable_q, armed_q, press_q;
   logic [CntW-1:0] cnt_q;
   logic            accept;

   assign accept = (sync2_q != stable_q) && (cnt_q == CntMax);

   // Left out of reset so a key held through reset is seen as low right away.
   always_ff @(posedge clock) begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         stable_q <= 1'b1;
         cnt_q    <= '0;
         press_q  <= 1'b0;
         armed_q  <= 1'b0;
      end else begin
         if (sync2_q == stable_q) begin
            cnt_q <= '0;
         end else if (accept) begin
            stable_q <= sync2_q;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
         press_q <= accept & ~sync2_q & armed_q;
         // Arms only once a released level is seen, so a key held over reset needs a re-press.
         armed_q <= armed_q | (stable_q & sync2_q);
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/stopwatch_control.sv
// Stopwatch front end: button debounce, start/stop/lap/clear FSM, and the gated count tick.
module stopwatch_control
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
   parameter int unsigned TICK_CYCLES     = TICK_10MS
) (
   input  logic                clock,
   input  logic                reset,
   stopwatch_control_if.slave  bus
);

   localparam int unsigned PrescW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_CYCLES - 1);

   state_e              state_q, state_d;
   logic                clear_q, clear_d;
   logic                tick_q;
   logic [PrescW-1:0]   presc_q;
   logic                start_ev, clear_ev;

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
      .clock   (clock),
      .reset   (reset),
      .key_n_i (bus.start_stop_n),
      .press_o (start_ev)
   );

   button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
      .clock   (clock),
      .reset   (reset),
      .key_n_i (bus.clear_lap_n),
      .press_o (clear_ev)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         clear_q <= 1'b1;
      end else begin
         state_q <= state_d;
         clear_q <= clear_d;
      end
   end

   // Start has priority; a clear_lap event in the same cycle is dropped.
   always_comb begin
      state_d = state_q;
      clear_d = 1'b0;
      if (start_ev) begin
         unique case (state_q)
            StIdle:    state_d = StRunning;
            StRunning: state_d = StPaused;
            StLap:     state_d = StPaused;
            StPaused:  state_d = StRunning;
         endcase
      end else if (clear_ev) begin
         unique case (state_q)
            StIdle:    clear_d = 1'b1;
            StRunning: state_d = StLap;
            StLap:     state_d = StRunning;
            StPaused: begin
               state_d = StIdle;
               clear_d = 1'b1;
            end
         endcase
      end
   end

   // Prescaler holds its value while paused so the fractional tick survives a pause.
   always_ff @(posedge clock) begin
      if (reset) begin
         presc_q <= '0;
         tick_q  <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (is_running(state_q)) begin
            if (presc_q == PrescMax) begin
               presc_q <= '0;
               tick_q  <= 1'b1;
            end else begin
               presc_q <= presc_q + 1'b1;
            end
         end else if (state_q == StIdle) begin
            presc_q <= '0;
         end
      end
   end

   assign bus.tick        = tick_q;
   assign bus.count_clear = clear_q | reset;
   assign bus.freeze      = (state_q == StLap);
   assign bus.running     = is_running(state_q);
   assign bus.state       = state_q;

endmodule

// File: tb/tb_stopwatch_control.sv
// Bench for stopwatch_control: directed vector table, corner-case sequences, random vs model.
module tb_stopwatch_control;

   localparam int unsigned D = 4;
   localparam int unsigned T = 5;

   logic clock = 1'b0;
   logic reset;

   stopwatch_control_if bus ();

   stopwatch_control #(.DEBOUNCE_CYCLES(D), .TICK_CYCLES(T)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: a level is accepted once the last D synchronized samples all disagree.
   logic         m_s1[2], m_s2[2], m_stable[2], m_armed[2], m_press[2];
   logic [D-1:0] m_hist[2];
   int           m_nsamp[2];
   int           m_state, m_presc;
   logic         m_tick, m_cc;
   int           start_next[4] = '{1, 3, 3, 1};
   int           clr_next[4]   = '{0, 2, 1, 0};

   int tick_cnt, cc_cnt, frz_cnt;

   typedef struct {
      logic rst, ss, cl;
      int   st, cc, tk;
   } vec_t;
   vec_t tbl[23];

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input logic r, input logic s, input logic c);
      logic raw[2];
      logic sync[2];
      logic prs_old[2];
      int   st;
      raw[0] = s;
      raw[1] = c;
      for (int b = 0; b < 2; b++) begin
         sync[b]    = m_s2[b];
         m_s2[b]    = m_s1[b];
         m_s1[b]    = raw[b];
         prs_old[b] = m_press[b];
      end
      st = m_state;
      if (r) begin
         m_state = 0;
         m_presc = 0;
         m_tick  = 1'b0;
         m_cc    = 1'b1;
         for (int b = 0; b < 2; b++) begin
            m_stable[b] = 1'b1;
            m_armed[b]  = 1'b0;
            m_press[b]  = 1'b0;
            m_hist[b]   = '0;
            m_nsamp[b]  = 0;
         end
      end else begin
         for (int b = 0; b < 2; b++) begin
            logic flip;
            m_hist[b] = {m_hist[b][D-2:0], sync[b]};
            if (m_nsamp[b] < D) m_nsamp[b]++;
            flip = (m_nsamp[b] == D) && (m_hist[b] == {D{~m_stable[b]}});
            m_press[b] = flip && !sync[b] && m_armed[b];
            if (m_stable[b] && sync[b]) m_armed[b] = 1'b1;
            if (flip) m_stable[b] = sync[b];
         end
         m_cc = 1'b0;
         if (prs_old[0]) begin
            m_state = start_next[st];
         end else if (prs_old[1]) begin
            m_state = clr_next[st];
            m_cc    = (st == 0) || (st == 3);
         end
         if (st == 1 || st == 2) begin
            m_tick  = (m_presc == T - 1);
            m_presc = (m_presc + 1) % T;
         end else begin
            m_tick = 1'b0;
            if (st == 0) m_presc = 0;
         end
      end
   endtask

   // Apply inputs for one cycle: compare outputs before the edge, then advance the model.
   task automatic step(input logic r, input logic s, input logic c);
      reset            = r;
      bus.start_stop_n = s;
      bus.clear_lap_n  = c;
      #1;
      check("state", bus.state, m_state);
      check("tick", bus.tick, m_tick);
      check("count_clear", bus.count_clear, m_cc | r);
      check("freeze", bus.freeze, m_state == 2);
      check("running", bus.running, m_state == 1 || m_state == 2);
      tick_cnt += bus.tick;
      cc_cnt   += bus.count_clear;
      frz_cnt  += bus.freeze;
      @(posedge clock);
      model_edge(r, s, c);
      @(negedge clock);
   endtask

   task automatic press(input bit s, input bit c, input int hold, input int rel);
      for (int i = 0; i < hold; i++) step(1'b0, !s, !c);
      for (int i = 0; i < rel; i++) step(1'b0, 1'b1, 1'b1);
   endtask

   initial begin
      for (int b = 0; b < 2; b++) begin
         m_s1[b] = 1'b1; m_s2[b] = 1'b1; m_stable[b] = 1'b1;
         m_armed[b] = 1'b0; m_press[b] = 1'b0; m_hist[b] = '0; m_nsamp[b] = 0;
      end
      m_state = 0; m_presc = 0; m_tick = 1'b0; m_cc = 1'b1;
      tick_cnt = 0; cc_cnt = 0; frz_cnt = 0;

      // Reset, then a clean start press held 10 cycles; expected values from the timing rules.
      tbl[0] = '{1'b1, 1'b1, 1'b1, 0, 1, 0};
      tbl[1] = '{1'b1, 1'b1, 1'b1, 0, 1, 0};
      tbl[2] = '{1'b0, 1'b1, 1'b1, 0, 1, 0};
      tbl[3] = '{1'b0, 1'b1, 1'b1, 0, 0, 0};
      for (int i = 4; i <= 10; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 0, 0, 0};
      for (int i = 11; i <= 13; i++) tbl[i] = '{1'b0, 1'b0, 1'b1, 1, 0, 0};
      for (int i = 14; i <= 22; i++) tbl[i] = '{1'b0, 1'b1, 1'b1, 1, 0, 0};
      tbl[16].tk = 1;
      tbl[21].tk = 1;

      reset = 1'b1;
      bus.start_stop_n = 1'b1;
      bus.clear_lap_n  = 1'b1;
      @(posedge clock);
      model_edge(1'b1, 1'b1, 1'b1);
      @(negedge clock);

      for (int i = 0; i < 23; i++) begin
         reset            = tbl[i].rst;
         bus.start_stop_n = tbl[i].ss;
         bus.clear_lap_n  = tbl[i].cl;
         #1;
         check("tbl_state", bus.state, tbl[i].st);
         check("tbl_count_clear", bus.count_clear, tbl[i].cc);
         check("tbl_tick", bus.tick, tbl[i].tk);
         step(tbl[i].rst, tbl[i].ss, tbl[i].cl);
      end

      // Bounce shorter than the debounce window is ignored.
      for (int i = 0; i < 12; i++) step(1'b0, ((i / 2) % 2) ? 1'b1 : 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
      check("bounce_state", bus.state, 1);

      // Lap in and out; ticks keep running during lap.
      press(1'b0, 1'b1, 6, 8);
      check("lap_state", bus.state, 2);
      check("lap_freeze", bus.freeze, 1);
      tick_cnt = 0;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
      check("lap_ticks", tick_cnt, 2);
      press(1'b0, 1'b1, 6, 8);
      check("unlap_state", bus.state, 1);
      check("unlap_freeze", bus.freeze, 0);

      // Pause holds the tick; resume; pause again and clear back to idle.
      press(1'b1, 1'b0, 6, 8);
      check("pause_state", bus.state, 3);
      tick_cnt = 0;
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
      check("pause_ticks", tick_cnt, 0);
      press(1'b1, 1'b0, 6, 8);
      check("resume_state", bus.state, 1);
      press(1'b1, 1'b0, 6, 8);
      check("pause2_state", bus.state, 3);
      cc_cnt = 0;
      press(1'b0, 1'b1, 6, 8);
      check("clear_state", bus.state, 0);
      check("clear_pulses", cc_cnt, 1);

      // Simultaneous presses in RUNNING: start wins, no lap.
      press(1'b1, 1'b0, 6, 8);
      check("sim_pre_state", bus.state, 1);
      frz_cnt = 0;
      press(1'b1, 1'b1, 6, 8);
      check("sim_state", bus.state, 3);
      check("sim_freeze_seen", frz_cnt, 0);

      // Reset while in LAP aborts to idle.
      press(1'b1, 1'b0, 6, 8);
      press(1'b0, 1'b1, 6, 8);
      check("rst_lap_pre", bus.state, 2);
      step(1'b1, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      check("rst_lap_state", bus.state, 0);
      check("rst_lap_freeze", bus.freeze, 0);
      step(1'b0, 1'b1, 1'b1);

      // Key held through reset release is not a press until re-pressed.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 15; i++) step(1'b0, 1'b0, 1'b1);
      check("held_state", bus.state, 0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b1);
      press(1'b1, 1'b0, 6, 8);
      check("repress_state", bus.state, 1);

      // Random held levels with occasional reset, checked cycle by cycle against the model.
      for (int k = 0; k < 400; k++) begin
         logic rs, ls, lc;
         int   len;
         rs  = ($urandom_range(0, 40) == 0);
         ls  = 1'($urandom_range(0, 1));
         lc  = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 9);
         for (int j = 0; j < len; j++) step(rs, ls, lc);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
